exp_share_ctrl: RTL

//  Shares one `exponent` Taylor-series core (7-cycle iterative, enable/ack protocol) between NUM_REQ requesters.

---
 rtl/exp_share_ctrl_pkg.sv | 15 +
 rtl/exp_rr_pick.sv | 39 +++
 rtl/exp_share_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/exp_share_ctrl_pkg.sv
// Shared definitions for the exponent-core sharing controller.
// FSM encodings and the IEEE-754 constants used on the result path.
package exp_share_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam logic [31:0] FP_ZERO = 32'h0000_0000;
   localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/exp_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
// Returns the winner as one-hot and as an index; any_o flags a non-empty request vector.
module exp_rr_pick #(
   parameter int NUM_REQ = 4,
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   output logic [NUM_REQ-1:0] win_o,
   output logic [IW-1:0]      idx_o,
   output logic               any_o
);

   logic          found;
   logic [IW:0]   sum;
   logic [IW-1:0] cand;

   always_comb begin
      win_o = '0;
      idx_o = '0;
      any_o = |req_i;
      found = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, ptr_i} + (IW+1)'(k);
         if (sum >= (IW+1)'(NUM_REQ)) begin
            sum = sum - (IW+1)'(NUM_REQ);
         end
         cand = sum[IW-1:0];
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            win_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
   end

endmodule

// File: rtl/exp_share_ctrl.sv
// Shares one iterative exponent core between NUM_REQ requesters with round-robin grant,
// operand latching, result routing and a watchdog that aborts a core that never acks.
module exp_share_ctrl
   import exp_share_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ    = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic                          clk_p,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_x,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            done,
   output logic [DATA_WIDTH-1:0]         result,
   output logic                          busy,
   output logic                          err,
   output logic [DATA_WIDTH-1:0]         core_x,
   output logic                          core_enable,
   input  logic [DATA_WIDTH-1:0]         core_output_exp,
   input  logic                          core_ack
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [DATA_WIDTH-1:0] QNAN = DATA_WIDTH'(FP_QNAN);
   localparam logic [DATA_WIDTH-1:0] ZERO = DATA_WIDTH'(FP_ZERO);

   state_e                  state_q;
   logic [IW-1:0]           rr_ptr_q;
   logic [NUM_REQ-1:0]      win_q;
   logic [WW-1:0]           wd_cnt_q;
   logic [NUM_REQ-1:0]      gnt_q;
   logic [NUM_REQ-1:0]      done_q;
   logic [DATA_WIDTH-1:0]   result_q;
   logic [DATA_WIDTH-1:0]   core_x_q;
   logic                    busy_q;
   logic                    err_q;
   logic                    core_en_q;

   logic [NUM_REQ-1:0]      pick_win;
   logic [IW-1:0]           pick_idx;
   logic                    pick_any;
   logic [DATA_WIDTH-1:0]   pick_x;

   exp_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req_i (req),
      .ptr_i (rr_ptr_q),
      .win_o (pick_win),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   always_comb begin
      pick_x = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (pick_win[k]) begin
            pick_x = req_x[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk_p) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         rr_ptr_q  <= '0;
         win_q     <= '0;
         wd_cnt_q  <= '0;
         gnt_q     <= '0;
         done_q    <= '0;
         result_q  <= ZERO;
         core_x_q  <= ZERO;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
         core_en_q <= 1'b0;
      end else begin
         gnt_q  <= '0;
         done_q <= '0;
         case (state_q)
            ST_IDLE: begin
               core_en_q <= 1'b0;
               wd_cnt_q  <= '0;
               if (pick_any) begin
                  core_x_q <= pick_x;
                  gnt_q    <= pick_win;
                  win_q    <= pick_win;
                  rr_ptr_q <= (pick_idx == IW'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
                  busy_q   <= 1'b1;
                  state_q  <= ST_LOAD;
               end else begin
                  busy_q   <= 1'b0;
               end
            end
            // Enable stays low across this edge so the core reloads its seed and divisors.
            ST_LOAD: begin
               core_en_q <= 1'b1;
               state_q   <= ST_RUN;
            end
            ST_RUN: begin
               wd_cnt_q <= wd_cnt_q + 1'b1;
               if (core_ack) begin
                  result_q  <= core_output_exp;
                  done_q    <= win_q;
                  core_en_q <= 1'b0;
                  state_q   <= ST_DONE;
               end else if (wd_cnt_q == WW'(TIMEOUT-1)) begin
                  result_q  <= QNAN;
                  done_q    <= win_q;
                  err_q     <= 1'b1;
                  core_en_q <= 1'b0;
                  state_q   <= ST_DONE;
               end
            end
            // Pending work keeps busy up through the one-cycle IDLE turnaround.
            ST_DONE: begin
               core_en_q <= 1'b0;
               wd_cnt_q  <= '0;
               busy_q    <= |req;
               state_q   <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign gnt         = gnt_q;
   assign done        = done_q;
   assign result      = result_q;
   assign busy        = busy_q;
   assign err         = err_q;
   assign core_x      = core_x_q;
   assign core_enable = core_en_q;

endmodule
